// File: rtl/mux3_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux3_rr_arbiter
//
// Round-robin arbiter and sequencer that shares one 3:1 multiplexer datapath
// between three requesters. One winner is chosen at a time. The winner's
// data is latched and then presented on a single valid/ready output channel
// until the downstream accepts it. Priority rotates after every transfer, so
// no requester can starve under continuous contention.
//
// Parameters
//   WIDTH      data width of each requester input and of out_data
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req[2:0]   request per requester; bit k belongs to requester k
//   d0/d1/d2   requester data inputs, sampled only on the grant edge
//   out_ready  downstream accepts out_data this cycle
//   out_valid  out_data holds a granted item (registered)
//   out_data   latched data of the current winner (registered)
//   sel        mux select code: 0/1/2 = winner index, 3 = none (registered)
//   gnt        one-hot grant of the current winner, 0 when idle (registered)
//   ack        transfer-complete strobe to the winner (combinational)
// ---------------------------------------------------------------------------
module mux3_rr_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       sel,
  output logic [2:0]       gnt,
  output logic [2:0]       ack
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'd3;
  localparam logic [1:0] LAST_RST = 2'd2;

  state_t           state;
  logic [1:0]       last;

  logic [2:0]       masked_req;
  logic [2:0]       idle_pick;
  logic [2:0]       busy_pick;
  logic             idle_found;
  logic             busy_found;
  logic [1:0]       idle_idx;
  logic [1:0]       busy_idx;
  logic [WIDTH-1:0] idle_data;
  logic [WIDTH-1:0] busy_data;
  logic             transfer;

  // Modulo-3 increment of a requester index.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    logic [1:0] result;
    if (idx == 2'd2) begin
      result = 2'd0;
    end else begin
      result = idx + 2'd1;
    end
    return result;
  endfunction

  // Rotating-priority pick. The requester after 'ptr' is checked first and
  // 'ptr' itself last. The result is {found, index}; index is meaningless
  // when found is 0.
  function automatic logic [2:0] pick(input logic [2:0] r,
                                      input logic [1:0] ptr);
    logic [1:0] first;
    logic [1:0] second;
    logic [2:0] result;
    first  = next_idx(ptr);
    second = next_idx(first);
    result = {1'b0, SEL_NONE};
    if (r[first]) begin
      result = {1'b1, first};
    end else if (r[second]) begin
      result = {1'b1, second};
    end else if (r[ptr]) begin
      result = {1'b1, ptr};
    end
    return result;
  endfunction

  // 3:1 data mux driven by a winner index.
  function automatic logic [WIDTH-1:0] mux3(input logic [1:0]       idx,
                                            input logic [WIDTH-1:0] a0,
                                            input logic [WIDTH-1:0] a1,
                                            input logic [WIDTH-1:0] a2);
    logic [WIDTH-1:0] result;
    case (idx)
      2'd0:    result = a0;
      2'd1:    result = a1;
      2'd2:    result = a2;
      default: result = '0;
    endcase
    return result;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    logic [2:0] result;
    case (idx)
      2'd0:    result = 3'b001;
      2'd1:    result = 3'b010;
      2'd2:    result = 3'b100;
      default: result = 3'b000;
    endcase
    return result;
  endfunction

  // The winner's req can still be high on its ack edge. That bit is masked
  // during back-to-back re-arbitration so the same requester is never
  // granted on two consecutive edges. It can win again from IDLE one cycle
  // later.
  assign masked_req = req & ~gnt;

  // In IDLE the stored pointer drives priority. On a transfer the pointer is
  // about to become the current winner (sel), so that value is used directly
  // for the back-to-back pick.
  assign idle_pick  = pick(req, last);
  assign busy_pick  = pick(masked_req, sel);

  assign idle_found = idle_pick[2];
  assign idle_idx   = idle_pick[1:0];
  assign busy_found = busy_pick[2];
  assign busy_idx   = busy_pick[1:0];

  assign idle_data  = mux3(idle_idx, d0, d1, d2);
  assign busy_data  = mux3(busy_idx, d0, d1, d2);

  assign transfer   = out_valid & out_ready;

  // ack is gated by out_valid, so it stays low whenever nothing is held.
  assign ack        = gnt & {3{transfer}};

  // Sequencer: every output except ack is a register updated here. This
  // guarantees no combinational path from req or data to out_data, sel or gnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= LAST_RST;
      out_valid <= 1'b0;
      out_data  <= '0;
      sel       <= SEL_NONE;
      gnt       <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (idle_found) begin
            state     <= BUSY;
            out_valid <= 1'b1;
            out_data  <= idle_data;
            sel       <= idle_idx;
            gnt       <= onehot(idle_idx);
          end
        end

        BUSY: begin
          if (transfer) begin
            last <= sel;
            if (busy_found) begin
              out_data <= busy_data;
              sel      <= busy_idx;
              gnt      <= onehot(busy_idx);
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
              sel       <= SEL_NONE;
              gnt       <= 3'b000;
            end
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          sel       <= SEL_NONE;
          gnt       <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux3_rr_arbiter
//
// Directed, self-checking bench for mux3_rr_arbiter. Inputs are driven #1
// after each rising edge. The registered outputs are sampled at that point.
// ack is sampled after the inputs for the coming edge have settled.
// ---------------------------------------------------------------------------
module tb_mux3_rr_arbiter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [2:0]       req;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       sel;
  logic [2:0]       gnt;
  logic [2:0]       ack;

  int checks;
  int errors;

  mux3_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .gnt       (gnt),
    .ack       (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point. Every check is counted here and every mismatch
  // is reported here.
  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic rdy);
    req       = r;
    out_ready = rdy;
    #1;
  endtask

  // Check the registered outputs that describe a held item (or idle).
  task automatic checkHeld(input string tag, input logic v,
                           input logic [1:0] s, input logic [2:0] g,
                           input logic [3:0] dat);
    checkOutput({tag, ".valid"}, 8'(out_valid), 8'(v));
    checkOutput({tag, ".sel"},   8'(sel),       8'(s));
    checkOutput({tag, ".gnt"},   8'(gnt),       8'(g));
    if (v) checkOutput({tag, ".data"}, 8'(out_data), 8'(dat));
  endtask

  // Expected grant order from reset under full contention.
  logic [1:0] exp_sel [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
  logic [2:0] exp_gnt [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [3:0] exp_dat [6] = '{4'h1, 4'h2, 4'h4, 4'h1, 4'h2, 4'h4};

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req       = 3'b000;
    out_ready = 1'b0;
    d0        = '0;
    d1        = '0;
    d2        = '0;

    // Reset state.
    repeat (3) tick();
    checkHeld("rst", 1'b0, 2'd3, 3'b000, 4'h0);
    checkOutput("rst.data", 8'(out_data), 8'h0);
    checkOutput("rst.ack", 8'(ack), 8'h0);
    rst = 1'b0;

    // Single requester; req held through ack, so masked re-arbitration sends
    // it to IDLE and regrants on the following edge.
    d1 = 4'h5;
    applyStimulus(3'b010, 1'b1);
    checkOutput("single.idle_ack", 8'(ack), 8'h0);
    tick();
    checkHeld("single.e1", 1'b1, 2'd1, 3'b010, 4'h5);
    checkOutput("single.e1.ack", 8'(ack), 8'(3'b010));
    tick();
    checkHeld("single.e2", 1'b0, 2'd3, 3'b000, 4'h0);
    checkOutput("single.e2.ack", 8'(ack), 8'h0);
    tick();
    checkHeld("single.e3", 1'b1, 2'd1, 3'b010, 4'h5);
    applyStimulus(3'b000, 1'b1);
    tick();
    checkHeld("single.e4", 1'b0, 2'd3, 3'b000, 4'h0);

    // Backpressure on requester 2 (pointer is now 1, so 2 is first anyway).
    d2 = 4'h8;
    applyStimulus(3'b100, 1'b0);
    tick();
    checkHeld("bp.grant", 1'b1, 2'd2, 3'b100, 4'h8);
    d2 = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("bp.hold.ack", 8'(ack), 8'h0);
      tick();
      checkHeld("bp.hold", 1'b1, 2'd2, 3'b100, 4'h8);
    end
    applyStimulus(3'b100, 1'b1);
    checkOutput("bp.ack", 8'(ack), 8'(3'b100));
    tick();
    checkHeld("bp.done", 1'b0, 2'd3, 3'b000, 4'h0);

    // Pointer wrap. last=2: req=101 -> 0.
    d0 = 4'h3; d1 = 4'h6; d2 = 4'h9;
    applyStimulus(3'b101, 1'b1);
    tick();
    checkHeld("wrap.after2", 1'b1, 2'd0, 3'b001, 4'h3);
    // last becomes 0, req=101 masked to 100 -> 2.
    tick();
    checkHeld("wrap.after0", 1'b1, 2'd2, 3'b100, 4'h9);
    // Bring requester 1 in: masked 010 -> 1.
    applyStimulus(3'b010, 1'b1);
    tick();
    checkHeld("wrap.grant1", 1'b1, 2'd1, 3'b010, 4'h6);
    // last becomes 1, req=011 masked to 001 -> 0.
    applyStimulus(3'b011, 1'b1);
    tick();
    checkHeld("wrap.after1", 1'b1, 2'd0, 3'b001, 4'h3);
    applyStimulus(3'b000, 1'b1);
    tick();
    checkHeld("wrap.idle", 1'b0, 2'd3, 3'b000, 4'h0);

    // Asynchronous reset mid-BUSY while holding 0xA.
    d0 = 4'hA;
    applyStimulus(3'b001, 1'b0);
    tick();
    checkHeld("arst.busy", 1'b1, 2'd0, 3'b001, 4'hA);
    #2;
    rst = 1'b1;
    #1;
    checkHeld("arst.now", 1'b0, 2'd3, 3'b000, 4'h0);
    checkOutput("arst.data", 8'(out_data), 8'h0);
    checkOutput("arst.ack", 8'(ack), 8'h0);
    @(negedge clk);
    rst = 1'b0;

    // Full contention from reset: rotation 0,1,2,0,1,2 with no gap.
    d0 = 4'h1; d1 = 4'h2; d2 = 4'h4;
    applyStimulus(3'b111, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkHeld($sformatf("full.%0d", i), 1'b1, exp_sel[i], exp_gnt[i],
                exp_dat[i]);
    end
    applyStimulus(3'b000, 1'b1);
    tick();
    checkHeld("full.end", 1'b0, 2'd3, 3'b000, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
